enemy_sprite_locator: RTL and testbench
=======================================

// Module: enemy_sprite_locator
// PURPOSE
//  Tracks a row of NUM_ENEMIES enemies (group position, alive mask, march direction, animation frame)
//  and, per pixel, decides which live enemy covers (hcount_in, vcount_in). Produces the sprite ROM
//  address and in-sprite flag consumed by the enemy sprite/palette stage. Sits between the video
//  timing generator and that stage. Outputs are registered.
// PARAMETERS
//  NUM_ENEMIES  8    enemies in the row, index 0 = leftmost
//  SPR_W        16   sprite width, pixels
//  SPR_H        16   height of one animation frame; the ROM holds 3 frames stacked (16x48 = 768 words)
//  SPACING      24   x pitch between enemy i and i+1 (>=1; overlap allowed, lowest index wins)
//  X0 / Y0      64 / 40  group origin after reset/respawn
//  STEP_X       4    pixels moved per move tick
//  DROP_Y       8    pixels descended at an edge
//  MOVE_PERIOD  4    frames per move tick
//  ANIM_PERIOD  16   frames per animation-frame advance
//  SCREEN_W     1280 / BOTTOM_Y 600  playfield limits
// PORTS
//  pixel_clk_in      in   1   pixel clock
//  rst_in            in   1   asynchronous, active-high reset
//  hcount_in         in   11  current pixel x
//  vcount_in         in   10  current pixel y
//  new_frame_in      in   1   one-cycle pulse at start of vertical blank
//  kill_valid_in     in   1   kill request strobe
//  kill_idx_in       in   $clog2(NUM_ENEMIES)  enemy to kill
//  respawn_in        in   1   restore full row at origin
//  image_addr_out    out  10  sprite ROM address
//  in_sprite_out     out  1   pixel covered by a live enemy
//  hit_idx_out       out  $clog2(NUM_ENEMIES)  index of covering enemy (0 when in_sprite_out=0)
//  alive_out         out  NUM_ENEMIES  alive mask
//  all_dead_out      out  1   alive mask == 0
//  reached_bottom_out out 1   sticky: group bottom hit BOTTOM_Y
// BEHAVIOUR
//  Reset (async): gx=X0, gy=Y0, dir=RIGHT, alive=all 1, frame_cnt=0, anim=0, reached_bottom=0;
//   image_addr_out=0, in_sprite_out=0, hit_idx_out=0. all_dead_out=0.
//  Enemy i box: x in [gx+i*SPACING, +SPR_W), y in [gy, gy+SPR_H); only if alive[i].
//  Pixel pipe, latency 2: cycle 1 registers per-enemy hit vector and dx=hcount-x_i, dy=vcount-gy;
//   cycle 2 priority-encodes (lowest index) and registers outputs.
//   image_addr_out = (anim*SPR_H + dy)*SPR_W + dx, range 0..767. No hit -> addr 0, in_sprite 0, idx 0.
//  Subtractions done in 12 bits; negative results are misses, never wrap into a hit.
//  Movement FSM, states MARCH_R, MARCH_L, DESCEND, HALT; evaluated only on new_frame_in:
//   frame_cnt increments, wraps at MOVE_PERIOD-1 -> move tick; anim advances 0->1->2->0 every ANIM_PERIOD frames.
//   MARCH_R tick: if rightmost live x + SPR_W + STEP_X > SCREEN_W -> DESCEND, else gx += STEP_X.
//   MARCH_L tick: if leftmost live x < STEP_X -> DESCEND, else gx -= STEP_X.
//   DESCEND (next tick): gy += DROP_Y, flip dir, go to MARCH_L/MARCH_R.
//   If gy+SPR_H >= BOTTOM_Y after any update -> HALT, reached_bottom_out=1 (sticky until reset/respawn).
//   HALT or all_dead: no position change; anim still advances.
//  Leftmost/rightmost computed from alive mask; edge tests ignore dead enemies.
//  Kill: kill_valid_in with idx<NUM_ENEMIES clears alive[idx] next cycle; idx>=NUM_ENEMIES or already dead: no effect.
//  Respawn: reloads reset values next cycle except pixel pipe. Respawn + kill same cycle: respawn wins.
//  Kill + new_frame_in same cycle: both apply; edge test uses pre-kill mask.
//  Position/alive changes are only visible to pixel pipe from the cycle after update (no mid-pixel glitch guarantee
//   needed outside blank; callers kill only during blank is NOT required).
// TESTING
//  Reset mid-frame -> next edge all outputs at reset values, alive_out=8'hFF, gx=64, gy=40.
//  Pixel (64,40) -> 2 cycles later in_sprite=1, idx=0, addr=0; (64+24+15,40+15) -> idx=1, addr=255.
//  Pixel (63,40) and (64,56) -> in_sprite=0, addr=0; after kill idx 0, pixel (64,40) -> in_sprite=0.
//  SPACING=8, pixel (72,40) -> idx=0 (priority), addr=8; 16 new_frame pulses -> addr=256+8.
//  Pulse new_frame until right edge: gx stops, next tick gy=48, dir LEFT, gx decreases by 4.
//  Kill all 8 -> all_dead_out=1 one cycle after last; respawn+kill same cycle -> alive_out=8'hFF.

Source files
------------

// File: rtl/enemy_sprite_locator.sv
// enemy_sprite_locator: tracks a marching row of enemies and, per pixel,
// reports which live enemy covers it plus the sprite ROM address.
module enemy_sprite_locator #(
    parameter int NUM_ENEMIES = 8,
    parameter int SPR_W       = 16,
    parameter int SPR_H       = 16,
    parameter int SPACING     = 24,
    parameter int X0          = 64,
    parameter int Y0          = 40,
    parameter int STEP_X      = 4,
    parameter int DROP_Y      = 8,
    parameter int MOVE_PERIOD = 4,
    parameter int ANIM_PERIOD = 16,
    parameter int SCREEN_W    = 1280,
    parameter int BOTTOM_Y    = 600,
    localparam int IW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   new_frame_in,
    input  logic                   kill_valid_in,
    input  logic [IW-1:0]          kill_idx_in,
    input  logic                   respawn_in,
    output logic [9:0]             image_addr_out,
    output logic                   in_sprite_out,
    output logic [IW-1:0]          hit_idx_out,
    output logic [NUM_ENEMIES-1:0] alive_out,
    output logic                   all_dead_out,
    output logic                   reached_bottom_out
);

    localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int YW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
    localparam int FW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
    localparam int AW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;

    typedef enum logic [1:0] {MARCH_R, MARCH_L, DESCEND, HALT} state_t;

    state_t                 state;
    logic                   dir_right;
    logic signed [11:0]     gx;
    logic [11:0]            gy;
    logic [NUM_ENEMIES-1:0] alive;
    logic [FW-1:0]          frame_cnt;
    logic [AW-1:0]          anim_cnt;
    logic [1:0]             anim;
    logic                   reached_bottom;

    logic                   move_tick;
    logic [(1<<IW)-1:0]     kill_mask;
    int                     lidx, ridx, lx, rx, gy_drop;

    assign move_tick = (frame_cnt == FW'(MOVE_PERIOD - 1));

    // Edge tests only look at the outermost live enemies.
    always_comb begin
        lidx = 0;
        ridx = 0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--)
            if (alive[i]) lidx = i;
        for (int i = 0; i < NUM_ENEMIES; i++)
            if (alive[i]) ridx = i;
        lx      = int'(gx) + lidx * SPACING;
        rx      = int'(gx) + ridx * SPACING;
        gy_drop = int'(gy) + DROP_Y;
        kill_mask = '0;
        kill_mask[kill_idx_in] = 1'b1;
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= MARCH_R;
            dir_right      <= 1'b1;
            gx             <= 12'(X0);
            gy             <= 12'(Y0);
            alive          <= '1;
            frame_cnt      <= '0;
            anim_cnt       <= '0;
            anim           <= 2'd0;
            reached_bottom <= 1'b0;
        end else if (respawn_in) begin
            state          <= MARCH_R;
            dir_right      <= 1'b1;
            gx             <= 12'(X0);
            gy             <= 12'(Y0);
            alive          <= '1;
            frame_cnt      <= '0;
            anim_cnt       <= '0;
            anim           <= 2'd0;
            reached_bottom <= 1'b0;
        end else begin
            if (kill_valid_in)
                alive <= alive & ~kill_mask[NUM_ENEMIES-1:0];
            if (new_frame_in) begin
                frame_cnt <= move_tick ? '0 : frame_cnt + FW'(1);
                if (anim_cnt == AW'(ANIM_PERIOD - 1)) begin
                    anim_cnt <= '0;
                    anim     <= (anim == 2'd2) ? 2'd0 : anim + 2'd1;
                end else begin
                    anim_cnt <= anim_cnt + AW'(1);
                end
                if (move_tick && alive != '0) begin
                    unique case (state)
                        MARCH_R: begin
                            if (rx + SPR_W + STEP_X > SCREEN_W)
                                state <= DESCEND;
                            else
                                gx <= gx + 12'(STEP_X);
                        end
                        MARCH_L: begin
                            if (lx < STEP_X)
                                state <= DESCEND;
                            else
                                gx <= gx - 12'(STEP_X);
                        end
                        DESCEND: begin
                            gy        <= 12'(gy_drop);
                            dir_right <= ~dir_right;
                            if (gy_drop + SPR_H >= BOTTOM_Y) begin
                                state          <= HALT;
                                reached_bottom <= 1'b1;
                            end else begin
                                state <= dir_right ? MARCH_L : MARCH_R;
                            end
                        end
                        HALT:    state <= HALT;
                        default: state <= HALT;
                    endcase
                end
            end
        end
    end

    // Stage 1: per-enemy box test. Unsigned compare makes negative offsets miss.
    logic [11:0]            dx [NUM_ENEMIES];
    logic [11:0]            dy;
    logic [NUM_ENEMIES-1:0] hit;

    always_comb begin
        dy = {2'b00, vcount_in} - gy;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            dx[i]  = {1'b0, hcount_in} - (gx + 12'(i * SPACING));
            hit[i] = alive[i] && (dx[i] < 12'(SPR_W)) && (dy < 12'(SPR_H));
        end
    end

    logic [NUM_ENEMIES-1:0] s1_hit;
    logic [XW-1:0]          s1_dx [NUM_ENEMIES];
    logic [YW-1:0]          s1_dy;
    logic [1:0]             s1_anim;

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            s1_hit  <= '0;
            s1_dy   <= '0;
            s1_anim <= 2'd0;
            for (int i = 0; i < NUM_ENEMIES; i++)
                s1_dx[i] <= '0;
        end else begin
            s1_hit  <= hit;
            s1_dy   <= dy[YW-1:0];
            s1_anim <= anim;
            for (int i = 0; i < NUM_ENEMIES; i++)
                s1_dx[i] <= dx[i][XW-1:0];
        end
    end

    // Stage 2: lowest index wins where sprites overlap.
    logic          pe_found;
    logic [IW-1:0] pe_idx;
    logic [XW-1:0] pe_dx;

    always_comb begin
        pe_found = 1'b0;
        pe_idx   = '0;
        pe_dx    = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (s1_hit[i]) begin
                pe_found = 1'b1;
                pe_idx   = IW'(i);
                pe_dx    = s1_dx[i];
            end
        end
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            image_addr_out <= '0;
            in_sprite_out  <= 1'b0;
            hit_idx_out    <= '0;
        end else begin
            in_sprite_out  <= pe_found;
            hit_idx_out    <= pe_found ? pe_idx : '0;
            image_addr_out <= pe_found
                ? 10'((int'(s1_anim) * SPR_H + int'(s1_dy)) * SPR_W + int'(pe_dx))
                : '0;
        end
    end

    assign alive_out          = alive;
    assign all_dead_out       = (alive == '0);
    assign reached_bottom_out = reached_bottom;

endmodule

// File: tb/tb_enemy_sprite_locator.sv
// Bench for enemy_sprite_locator: vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural row model.
module tb_enemy_sprite_locator;

    localparam int N  = 8;
    localparam int SP = 24;
    localparam int SW = 16;
    localparam int SH = 16;

    logic        clk;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        new_frame;
    logic        kill_valid;
    logic [2:0]  kill_idx;
    logic        respawn;

    logic [9:0]  addr;
    logic        in_sprite;
    logic [2:0]  hit_idx;
    logic [7:0]  alive;
    logic        all_dead;
    logic        bottom;

    logic [9:0]  o_addr;
    logic        o_in;
    logic [2:0]  o_idx;
    logic [7:0]  o_alive;
    logic        o_dead;
    logic        o_bottom;

    enemy_sprite_locator dut (
        .pixel_clk_in       (clk),
        .rst_in             (rst),
        .hcount_in          (hcount),
        .vcount_in          (vcount),
        .new_frame_in       (new_frame),
        .kill_valid_in      (kill_valid),
        .kill_idx_in        (kill_idx),
        .respawn_in         (respawn),
        .image_addr_out     (addr),
        .in_sprite_out      (in_sprite),
        .hit_idx_out        (hit_idx),
        .alive_out          (alive),
        .all_dead_out       (all_dead),
        .reached_bottom_out (bottom)
    );

    // Tight spacing, narrow screen, shallow bottom: overlap and halt corners.
    enemy_sprite_locator #(
        .SPACING  (8),
        .SCREEN_W (200),
        .BOTTOM_Y (64)
    ) ovl (
        .pixel_clk_in       (clk),
        .rst_in             (rst),
        .hcount_in          (hcount),
        .vcount_in          (vcount),
        .new_frame_in       (new_frame),
        .kill_valid_in      (1'b0),
        .kill_idx_in        (3'd0),
        .respawn_in         (respawn),
        .image_addr_out     (o_addr),
        .in_sprite_out      (o_in),
        .hit_idx_out        (o_idx),
        .alive_out          (o_alive),
        .all_dead_out       (o_dead),
        .reached_bottom_out (o_bottom)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_gx, m_gy, m_fc, m_ac, m_anim;
    bit m_right, m_desc, m_halt, m_bot;
    bit [7:0] m_alive;

    function automatic void check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic void m_reset();
        m_gx = 64; m_gy = 40; m_fc = 0; m_ac = 0; m_anim = 0;
        m_right = 1; m_desc = 0; m_halt = 0; m_bot = 0;
        m_alive = 8'hFF;
    endfunction

    function automatic int leftmost_x();
        for (int i = 0; i < N; i++)
            if (m_alive[i]) return m_gx + i * SP;
        return 0;
    endfunction

    function automatic int rightmost_x();
        for (int i = N - 1; i >= 0; i--)
            if (m_alive[i]) return m_gx + i * SP;
        return 0;
    endfunction

    function automatic void m_frame();
        bit tick;
        tick = (m_fc == 3);
        m_fc = tick ? 0 : m_fc + 1;
        m_ac++;
        if (m_ac == 16) begin
            m_ac = 0;
            m_anim = (m_anim + 1) % 3;
        end
        if (tick && !m_halt && m_alive != 0) begin
            if (m_desc) begin
                m_gy += 8;
                m_right = !m_right;
                m_desc = 0;
                if (m_gy + SH >= 600) begin
                    m_halt = 1;
                    m_bot = 1;
                end
            end else if (m_right) begin
                if (rightmost_x() + SW + 4 > 1280) m_desc = 1;
                else m_gx += 4;
            end else begin
                if (leftmost_x() < 4) m_desc = 1;
                else m_gx -= 4;
            end
        end
    endfunction

    function automatic void ref_pix(input int h, input int v,
                                    output bit hit, output int idx, output int a);
        hit = 0; idx = 0; a = 0;
        for (int i = 0; i < N; i++) begin
            int x;
            x = m_gx + i * SP;
            if (!hit && m_alive[i] && h >= x && h < x + SW &&
                v >= m_gy && v < m_gy + SH) begin
                hit = 1;
                idx = i;
                a = (m_anim * SH + (v - m_gy)) * SW + (h - x);
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input bit nf, input bit kv, input int ki, input bit rs);
        new_frame = nf; kill_valid = kv; kill_idx = 3'(ki); respawn = rs;
        step();
        new_frame = 0; kill_valid = 0; respawn = 0;
        if (rs) m_reset();
        else begin
            if (nf) m_frame();
            if (kv) m_alive[ki] = 1'b0;
        end
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) apply(1, 0, 0, 0);
    endtask

    task automatic status(input string nm);
        check({nm, "_alive"}, int'(alive), int'(m_alive));
        check({nm, "_dead"}, int'(all_dead), int'(m_alive == 0));
        check({nm, "_bottom"}, int'(bottom), int'(m_bot));
    endtask

    task automatic probe(input int h, input int v, input string nm);
        bit hit;
        int idx, a;
        hcount = 11'(h);
        vcount = 10'(v);
        step();
        step();
        ref_pix(h, v, hit, idx, a);
        check({nm, "_in"}, int'(in_sprite), int'(hit));
        check({nm, "_idx"}, int'(hit_idx), idx);
        check({nm, "_addr"}, int'(addr), a);
    endtask

    typedef struct {
        int h;
        int v;
        int hit;
        int idx;
        int a;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int gxs, h, v, r;
        vecs[0]  = '{64,  40, 1, 0, 0};
        vecs[1]  = '{103, 55, 1, 1, 255};
        vecs[2]  = '{63,  40, 0, 0, 0};
        vecs[3]  = '{64,  56, 0, 0, 0};
        vecs[4]  = '{79,  40, 1, 0, 15};
        vecs[5]  = '{80,  40, 0, 0, 0};
        vecs[6]  = '{88,  41, 1, 1, 16};
        vecs[7]  = '{232, 47, 1, 7, 112};
        vecs[8]  = '{248, 40, 0, 0, 0};
        vecs[9]  = '{64,  39, 0, 0, 0};
        vecs[10] = '{247, 55, 1, 7, 255};

        rst = 1; hcount = 0; vcount = 0; new_frame = 0;
        kill_valid = 0; kill_idx = 0; respawn = 0;
        m_reset();
        step();
        step();
        check("rst_in_sprite", int'(in_sprite), 0);
        check("rst_addr", int'(addr), 0);
        check("rst_idx", int'(hit_idx), 0);
        check("rst_alive", int'(alive), 255);
        check("rst_dead", int'(all_dead), 0);
        check("rst_bottom", int'(bottom), 0);
        rst = 0;
        step();

        foreach (vecs[i]) begin
            hcount = 11'(vecs[i].h);
            vcount = 10'(vecs[i].v);
            step();
            step();
            check($sformatf("vec%0d_in", i), int'(in_sprite), vecs[i].hit);
            check($sformatf("vec%0d_idx", i), int'(hit_idx), vecs[i].idx);
            check($sformatf("vec%0d_addr", i), int'(addr), vecs[i].a);
        end

        // Overlapping sprites: lowest index wins, then animation frame 1.
        hcount = 11'd72; vcount = 10'd40;
        step(); step();
        check("ovl_prio_in", int'(o_in), 1);
        check("ovl_prio_idx", int'(o_idx), 0);
        check("ovl_prio_addr", int'(o_addr), 8);
        hcount = 11'd80;
        step(); step();
        check("ovl_e1_idx", int'(o_idx), 1);
        check("ovl_e1_addr", int'(o_addr), 8);
        frames(16);
        probe(88, 40, "anim1");
        check("ovl_anim_in", int'(o_in), 1);
        check("ovl_anim_idx", int'(o_idx), 0);
        check("ovl_anim_addr", int'(o_addr), 264);

        apply(0, 1, 3, 0);
        status("kill3");

        // Asynchronous reset in the middle of active video.
        probe(m_gx, m_gy, "pre_rst");
        rst = 1;
        #1;
        check("arst_in", int'(in_sprite), 0);
        check("arst_addr", int'(addr), 0);
        check("arst_idx", int'(hit_idx), 0);
        check("arst_alive", int'(alive), 255);
        step();
        rst = 0;
        m_reset();
        probe(64, 40, "post_rst");
        probe(63, 40, "post_rst_miss");
        status("post_rst");

        // Narrow-screen instance: edge, single descend, halt at bottom.
        frames(68);
        check("ovl_bottom_early", int'(o_bottom), 0);
        frames(4);
        check("ovl_bottom_set", int'(o_bottom), 1);
        frames(8);
        probe(128, 48, "ovl_halt_main");
        check("ovl_halt_in", int'(o_in), 1);
        check("ovl_halt_addr", int'(o_addr), 512);
        probe(127, 48, "ovl_halt_main2");
        check("ovl_halt_miss", int'(o_in), 0);
        apply(0, 0, 0, 1);
        check("ovl_bottom_clr", int'(o_bottom), 0);

        // March right to the screen edge, descend, turn left.
        for (int k = 0; k < 1200 && !m_desc; k++) apply(1, 0, 0, 0);
        gxs = m_gx;
        probe(gxs, 40, "edge_stop");
        probe(gxs - 1, 40, "edge_stop_l");
        frames(4);
        probe(gxs, 48, "desc_hit");
        probe(gxs, 47, "desc_miss");
        frames(4);
        probe(gxs - 4, 48, "left_hit");
        probe(gxs + 12, 48, "left_dx");

        // Kill sequence and respawn priority.
        apply(0, 0, 0, 1);
        apply(0, 1, 0, 0);
        probe(m_gx, m_gy, "kill0_pix");
        check("kill0_miss", int'(in_sprite), 0);
        for (int k = 1; k < N; k++) begin
            apply(0, 1, k, 0);
            check($sformatf("dead_after_%0d", k), int'(all_dead), int'(k == N - 1));
        end
        apply(0, 1, 5, 0);
        status("kill_dead_again");
        apply(0, 1, 2, 1);
        check("respawn_kill", int'(alive), 255);

        for (int it = 0; it < 3000; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                apply(int'($urandom_range(0, 1)) == 1, 1, int'($urandom_range(0, 7)), 1);
                status("rnd_resp");
            end else if (r < 13) begin
                apply(int'($urandom_range(0, 1)) == 1, 1, int'($urandom_range(0, 7)), 0);
                status("rnd_kill");
            end else if (r < 60) begin
                apply(1, 0, 0, 0);
                status("rnd_frame");
            end else begin
                h = m_gx - 4 + int'($urandom_range(0, N * SP + 8));
                v = m_gy - 4 + int'($urandom_range(0, SH + 8));
                if (h < 0) h = 0;
                if (h > 2047) h = 2047;
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                probe(h, v, "rnd_pix");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
